// File: rtl/fma16_pkg.sv
// Shared constants, rounding-mode encoding and stage payload for the fp16 FMA back end.
package fma16_pkg;

  localparam int unsigned NF     = 10;
  localparam int unsigned EW     = 7;
  localparam int unsigned EXPW   = 5;
  localparam int unsigned SUMW   = 36;
  localparam int unsigned BIAS   = 15;
  localparam int unsigned EMAX   = 31;
  localparam int unsigned NFLAGS = 3;

  localparam int unsigned FLAG_NX = 0;
  localparam int unsigned FLAG_UF = 1;
  localparam int unsigned FLAG_OF = 2;

  typedef enum logic [1:0] {
    RZ  = 2'b00,
    RNE = 2'b01,
    RM  = 2'b10,
    RP  = 2'b11
  } rmode_t;

  // Normalised operand held between the normalise and round stages
  typedef struct packed {
    logic          sign;
    logic [EW-1:0] exp;
    logic [NF:0]   sig;
    logic          guard;
    logic          sticky;
    logic          zero;
    logic          zsign;
    rmode_t        rmode;
  } s1_t;

endpackage

// File: rtl/fma16_lzc.sv
// Combinational leading-zero counter; returns W when the input is all zeros.
module fma16_lzc #(
  parameter int unsigned W  = 35,
  parameter int unsigned CW = $clog2(W + 1)
) (
  input  logic [W-1:0]  a_i,
  output logic [CW-1:0] cnt_o
);

  // Ascending scan: the highest set bit is the last one to write the count
  always_comb begin
    cnt_o = CW'(W);
    for (int unsigned i = 0; i < W; i++) begin
      if (a_i[i]) cnt_o = CW'(W - 1 - i);
    end
  end

endmodule

// File: rtl/fma16_postnorm.sv
// fp16 FMA back end: normalise the raw sum magnitude, round to binary16 and raise IEEE flags.
// Two pipeline stages with valid/ready on both sides.
module fma16_postnorm
  import fma16_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              Ss,
  input  logic [EW-1:0]     Se,
  input  logic [SUMW-1:0]   Sm,
  input  logic              ASticky,
  input  logic              ZeroSign,
  input  logic [1:0]        RoundMode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [15:0]       Result,
  output logic [NFLAGS-1:0] Flags
);

  localparam int unsigned XW  = EW + 2;
  localparam int unsigned SHW = $clog2(SUMW + 1);
  localparam int unsigned LZW = SUMW - 1;
  localparam int unsigned GB  = SUMW - 3 - NF;
  localparam int unsigned RW  = EW + NF + 1;
  localparam int unsigned EXW = EW + 1;
  localparam logic [EW-1:0] SE_MAX = {1'b0, {(EW-1){1'b1}}};

  logic              s1_v_q, s2_v_q;
  s1_t               s1_q, s1_d;
  logic [15:0]       result_q, res_d;
  logic [NFLAGS-1:0] flags_q, flags_d;
  logic              s2_load;

  logic [SHW-1:0]        lz;
  logic signed [XW-1:0]  se_x, diff;
  logic [XW-1:0]         rsub;
  logic                  use_r, se_pos, shout;
  logic [SHW-1:0]        sh_r, sh_l;
  logic [EW-1:0]         e_n;
  logic [SUMW-1:0]       norm, rmask;

  fma16_lzc #(.W(LZW), .CW(SHW)) u_lzc (
    .a_i   (Sm[LZW-1:0]),
    .cnt_o (lz)
  );

  // Stage 1: pick shift direction/amount so the leading one lands on bit SUMW-2 or E clamps to 0
  always_comb begin
    se_x   = {{(XW-EW){Se[EW-1]}}, Se};
    diff   = se_x - $signed({{(XW-SHW){1'b0}}, lz});
    rsub   = XW'(1) - $unsigned(se_x);
    se_pos = ~Se[EW-1] & (|Se);
    use_r  = 1'b0;
    sh_r   = '0;
    sh_l   = '0;
    e_n    = '0;
    if (Sm[SUMW-1] && !Se[EW-1]) begin
      use_r = 1'b1;
      sh_r  = SHW'(1);
      e_n   = (Se == SE_MAX) ? Se : Se + EW'(1);
    end else if (!Sm[SUMW-1] && !diff[XW-1] && (|diff)) begin
      sh_l = lz;
      e_n  = EW'(diff);
    end else if (!Sm[SUMW-1] && se_pos) begin
      sh_l = SHW'(Se - EW'(1));
    end else begin
      use_r = 1'b1;
      sh_r  = (rsub > XW'(SUMW)) ? SHW'(SUMW) : SHW'(rsub);
    end

    norm  = use_r ? (Sm >> sh_r) : (Sm << sh_l);
    rmask = ~({SUMW{1'b1}} << sh_r);
    shout = use_r & (|(Sm & rmask));

    s1_d.sign   = Ss;
    s1_d.exp    = e_n;
    s1_d.sig    = norm[SUMW-2 -: NF+1];
    s1_d.guard  = norm[GB];
    s1_d.sticky = ASticky | shout | (|norm[GB-1:0]);
    s1_d.zero   = ~(|Sm) & ~ASticky;
    s1_d.zsign  = ZeroSign;
    s1_d.rmode  = rmode_t'(RoundMode);
  end

  logic           nx, inc, of, inf_sel;
  logic [RW-1:0]  rnd;
  logic [EXW-1:0] e_r;

  // Stage 2: round on {exp,frac} so a fraction carry bumps the exponent for free
  always_comb begin
    nx  = s1_q.guard | s1_q.sticky;
    inc = 1'b0;
    case (s1_q.rmode)
      RZ:  inc = 1'b0;
      RNE: inc = s1_q.guard & (s1_q.sig[0] | s1_q.sticky);
      RM:  inc = s1_q.sign & nx;
      RP:  inc = ~s1_q.sign & nx;
    endcase
    rnd     = {1'b0, s1_q.exp, s1_q.sig[NF-1:0]} + RW'(inc);
    e_r     = rnd[RW-1:NF];
    of      = (e_r >= EXW'(EMAX));
    inf_sel = (s1_q.rmode == RNE) | ((s1_q.rmode == RP) & ~s1_q.sign) |
              ((s1_q.rmode == RM) & s1_q.sign);

    res_d            = {s1_q.sign, e_r[EXPW-1:0], rnd[NF-1:0]};
    flags_d          = '0;
    flags_d[FLAG_NX] = nx;
    flags_d[FLAG_UF] = (s1_q.exp == '0) & nx;
    if (s1_q.zero) begin
      res_d   = {s1_q.zsign, (EXPW+NF)'(0)};
      flags_d = '0;
    end else if (of) begin
      res_d            = inf_sel ? {s1_q.sign, {EXPW{1'b1}}, {NF{1'b0}}}
                                 : {s1_q.sign, {(EXPW-1){1'b1}}, 1'b0, {NF{1'b1}}};
      flags_d          = '0;
      flags_d[FLAG_OF] = 1'b1;
      flags_d[FLAG_NX] = 1'b1;
    end
  end

  assign s2_load  = ~s2_v_q | out_ready;
  assign in_ready = reset_n & (~s1_v_q | s2_load);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1_v_q   <= 1'b0;
      s2_v_q   <= 1'b0;
      s1_q     <= '0;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      if (~s1_v_q | s2_load) begin
        s1_v_q <= in_valid;
        if (in_valid) s1_q <= s1_d;
      end
      if (s2_load) begin
        s2_v_q <= s1_v_q;
        if (s1_v_q) begin
          result_q <= res_d;
          flags_q  <= flags_d;
        end
      end
    end
  end

  assign out_valid = s2_v_q;
  assign Result    = result_q;
  assign Flags     = flags_q;

endmodule

// File: tb/tb_fma16_postnorm.sv
// Directed bench for fma16_postnorm: scoreboard of expected results, checked as outputs leave.
module tb_fma16_postnorm;
  import fma16_pkg::*;

  logic              clk = 1'b0;
  logic              reset_n, in_valid, in_ready, Ss, ASticky, ZeroSign, out_valid, out_ready;
  logic [EW-1:0]     Se;
  logic [SUMW-1:0]   Sm;
  logic [1:0]        RoundMode;
  logic [15:0]       Result;
  logic [NFLAGS-1:0] Flags;

  fma16_postnorm dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .Ss(Ss), .Se(Se), .Sm(Sm), .ASticky(ASticky), .ZeroSign(ZeroSign),
    .RoundMode(RoundMode), .out_valid(out_valid), .out_ready(out_ready),
    .Result(Result), .Flags(Flags)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic [15:0] res;
    logic [2:0]  flg;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad   = 0;
  int   next_id = 0;

  localparam logic [SUMW-1:0] SM_ONE = SUMW'(1) << 34;
  localparam logic [SUMW-1:0] SM_C   = SUMW'(1) << 35;
  localparam logic [SUMW-1:0] SM_3   = 36'h7_FF80_0000;
  localparam logic [SUMW-1:0] SM_30  = SUMW'(1) << 30;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, want);
    end
  endtask

  // Output monitor: hold-stability while stalled, and in-order scoreboard pop on transfer
  logic        held_v = 1'b0;
  logic [15:0] held_res;
  logic [2:0]  held_flg;
  always @(negedge clk) begin
    exp_t e;
    if (reset_n && out_valid) begin
      if (held_v) begin
        chk("hold_result", Result, held_res);
        chk("hold_flags", 16'(Flags), 16'(held_flg));
      end
      if (out_ready) begin
        held_v = 1'b0;
        if (sbq.size() == 0) begin
          total++;
          bad++;
          $error("FAIL unexpected_output: observed result=%h expected none", Result);
        end else begin
          e = sbq.pop_front();
          chk($sformatf("result_op%0d", e.id), Result, e.res);
          chk($sformatf("flags_op%0d", e.id), 16'(Flags), 16'(e.flg));
        end
      end else begin
        held_v   = 1'b1;
        held_res = Result;
        held_flg = Flags;
      end
    end else begin
      held_v = 1'b0;
    end
  end

  task automatic send(input logic [SUMW-1:0] sm, input logic [EW-1:0] se, input logic ss,
                      input logic ast, input logic zs, input rmode_t rm,
                      input logic [15:0] r, input logic [2:0] f);
    int   n;
    exp_t e;
    Sm = sm; Se = se; Ss = ss; ASticky = ast; ZeroSign = zs; RoundMode = rm;
    in_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 100);
    if (!in_ready) begin
      total++;
      bad++;
      $error("FAIL accept_timeout: observed in_ready=0 expected 1");
      in_valid = 1'b0;
    end else begin
      e.id = next_id; e.res = r; e.flg = f;
      sbq.push_back(e);
    end
    next_id++;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    in_valid = 1'b0;
    n = 0;
    while (sbq.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain_pending", 16'(sbq.size()), 16'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    Ss = 1'b0; Se = '0; Sm = '0; ASticky = 1'b0; ZeroSign = 1'b0; RoundMode = RNE;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 16'(out_valid), 16'd0);
    chk("rst_result", Result, 16'h0000);
    chk("rst_flags", 16'(Flags), 16'd0);
    chk("rst_in_ready", 16'(in_ready), 16'd0);
    reset_n = 1'b1;

    // Single op: latency check
    send(SM_ONE, EW'(15), 1'b0, 1'b0, 1'b0, RNE, 16'h3C00, 3'b000);
    in_valid = 1'b0;
    chk("lat_after_accept", 16'(out_valid), 16'd0);
    @(posedge clk);
    #1;
    chk("lat_two_cycles", 16'(out_valid), 16'd1);
    drain();

    // Directed back-to-back operations
    send(SM_C,   EW'(15), 1'b0, 1'b0, 1'b0, RNE, 16'h4000, 3'b000);
    send(SM_3,   EW'(15), 1'b0, 1'b0, 1'b0, RNE, 16'h4000, 3'b001);
    send(SM_3,   EW'(15), 1'b0, 1'b0, 1'b0, RZ,  16'h3FFF, 3'b001);
    send(SM_C,   EW'(30), 1'b0, 1'b0, 1'b0, RNE, 16'h7C00, 3'b101);
    send(SM_C,   EW'(30), 1'b0, 1'b0, 1'b0, RZ,  16'h7BFF, 3'b101);
    send(SM_C,   EW'(30), 1'b1, 1'b0, 1'b0, RM,  16'hFC00, 3'b101);
    send(SM_C,   EW'(30), 1'b1, 1'b0, 1'b0, RP,  16'hFBFF, 3'b101);
    send(SM_ONE, EW'(-5), 1'b0, 1'b0, 1'b0, RNE, 16'h0010, 3'b000);
    send(SM_ONE, EW'(-5), 1'b0, 1'b1, 1'b0, RP,  16'h0011, 3'b011);
    send('0,     EW'(15), 1'b0, 1'b0, 1'b1, RNE, 16'h8000, 3'b000);
    send('0,     EW'(15), 1'b0, 1'b1, 1'b0, RP,  16'h0001, 3'b011);
    send(SM_3,   EW'(0),  1'b0, 1'b0, 1'b0, RNE, 16'h0400, 3'b011);
    send(SM_30,  EW'(15), 1'b0, 1'b0, 1'b0, RNE, 16'h2C00, 3'b000);
    send(SM_30,  EW'(3),  1'b0, 1'b0, 1'b0, RNE, 16'h0100, 3'b000);
    send(SM_ONE | (SUMW'(1) << 23), EW'(15), 1'b0, 1'b0, 1'b0, RNE, 16'h3C00, 3'b001);
    send(SM_ONE | (SUMW'(3) << 23), EW'(15), 1'b0, 1'b0, 1'b0, RNE, 16'h3C02, 3'b001);
    send(SM_ONE | SUMW'(1), EW'(15), 1'b1, 1'b0, 1'b0, RM, 16'hBC01, 3'b001);
    send(SM_ONE | SUMW'(1), EW'(15), 1'b1, 1'b0, 1'b0, RP, 16'hBC00, 3'b001);
    drain();

    // Backpressure: two accepts fill the pipe, then in_ready must drop
    out_ready = 1'b0;
    send(SM_ONE, EW'(15), 1'b0, 1'b0, 1'b0, RNE, 16'h3C00, 3'b000);
    send(SM_C,   EW'(15), 1'b0, 1'b0, 1'b0, RNE, 16'h4000, 3'b000);
    Sm = SM_30; Se = EW'(15); Ss = 1'b0; ASticky = 1'b0; RoundMode = RNE; in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("stall_in_ready", 16'(in_ready), 16'd0);
      chk("stall_out_valid", 16'(out_valid), 16'd1);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    send(SM_30, EW'(15), 1'b0, 1'b0, 1'b0, RNE, 16'h2C00, 3'b000);
    drain();

    // Reset mid-stream drops in-flight work
    out_ready = 1'b0;
    send(SM_ONE, EW'(15), 1'b0, 1'b0, 1'b0, RNE, 16'h3C00, 3'b000);
    send(SM_C,   EW'(15), 1'b0, 1'b0, 1'b0, RNE, 16'h4000, 3'b000);
    in_valid = 1'b0;
    reset_n  = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_out_valid", 16'(out_valid), 16'd0);
    chk("midrst_in_ready", 16'(in_ready), 16'd0);
    sbq.delete();
    reset_n   = 1'b1;
    out_ready = 1'b1;
    send(SM_30, EW'(3), 1'b0, 1'b0, 1'b0, RNE, 16'h0100, 3'b000);
    drain();
    repeat (3) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
